charbuf_writer: RTL and testbench
=================================

Name: charbuf_writer

Overview:
- Write-side producer for the 64x32-cell colour character buffer. Port B of the buffer is read by the VGA text renderer; this block drives port A.
- Accepts a byte stream (UART/CPU console) over a valid/ready handshake. Interprets a small set of control codes and writes 16-bit cells to the buffer: {attr[7:0], char[7:0]}.
- Attribute byte layout: high nibble is background, low nibble is foreground.
- Maintains the cursor and the current attribute, and performs full-screen clear.

Parameters:
- COLS, 60, visible columns per row (1..64); the row stride is fixed at 64.
- ROWS, 17, visible rows (1..32).
- DEFAULT_ATTR, 8'h07, attribute applied at reset.

Ports:
- clk  in  1  system clock; same clock as buffer port A.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block can accept a byte this cycle.
- in_data  in  8  input byte.
- wr_ce  out  1  buffer write enable (to cea).
- wr_addr  out  11  buffer address {row[4:0], col[5:0]} (to ada).
- wr_data  out  16  {attr, char} (to din).
- cursor_col  out  6  current column.
- cursor_row  out  5  current row.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (clock edge with rst=1):
  - Cursor 0,0; attr=DEFAULT_ATTR; state IDLE.
  - wr_ce=0; wr_addr=0; wr_data=0; busy=0.
  - rst overrides everything, including a clear in progress (the sequence aborts immediately).
- States: IDLE, ESC_ATTR, CLEAR.
- Handshake:
  - in_ready=1 in IDLE and ESC_ATTR; 0 in CLEAR and during rst.
  - A byte is accepted on a clock edge where in_valid & in_ready; exactly one byte per cycle.
- Write outputs:
  - wr_ce, wr_addr and wr_data are registered. A write issued for an accepted byte appears the cycle after acceptance and lasts exactly one cycle.
  - wr_ce=0 in every cycle without a write.
- IDLE, byte decode:
  - 0x08 BS:
    - If col>0: col-=1, then write {attr,0x20} at the new position.
    - If col==0: no write, no move.
  - 0x0A LF: row+=1; col unchanged; no write.
  - 0x0D CR: col=0; no write.
  - 0x0C FF: enter CLEAR.
  - 0x1B ESC: enter ESC_ATTR; no write.
  - Any other value (including the glyphs 0x00-0x07 and 0x80-0xFF): write {attr,byte} at the cursor, then advance col.
- Cursor wrap:
  - Column advance past COLS-1 sets col=0 and row+=1.
  - Row increment past ROWS-1 sets row=0. The screen wraps to the top; it does not scroll.
  - Columns COLS..63 are never written by the cursor.
- ESC_ATTR: the next accepted byte (any value) becomes attr; return to IDLE; no write.
- CLEAR:
  - busy=1.
  - Writes {attr,0x20} to every address row 0..ROWS-1, col 0..63, in ascending order, one per cycle: ROWS*64 consecutive wr_ce cycles.
  - The first clear write appears the cycle after the FF is accepted.
  - After the final write: cursor=0,0; state IDLE; busy=0; in_ready=1 on the following cycle.
- Attribute latching: attr is captured when a write is issued. A later ESC never alters writes already issued.
- in_data is ignored when not accepted.

Optional Feature:
- Macro: CHARBUF_WRITER_CLEAR_ON_RESET_EN.
- Defined: on release of rst the block enters CLEAR automatically using DEFAULT_ATTR. busy=1 and in_ready=0 for ROWS*64 cycles, then IDLE.
- Undefined: the block enters IDLE after reset with no writes. The buffer keeps its initialisation contents.

Test Plan:
- Reset, then send 'A' (0x41) -> one cycle later wr_ce=1, wr_addr=0x000, wr_data=0x0741; cursor col=1, row=0.
- Send 0x1B, 0x1E, then 'x' (0x78) -> no write for the first two bytes; then wr_data=0x1E78 at the cursor address.
- Place cursor at col 59, row 16; send 'Z' -> write at addr {16,59}=0x43B; cursor then at col 0, row 0.
- Send 'a','b', then 0x08 -> write {attr,0x20} at col 1; cursor col=1. Then CR, then BS -> no write, cursor col 0.
- Send 0x0C with attr 0x07 -> in_ready=0, busy=1 for 1088 cycles, with 1088 writes of 0x0720 at addrs 0x000..0x43F in order; then cursor 0,0 and in_ready=1.
- Assert rst mid-clear (after 100 writes) -> wr_ce=0, busy=0, cursor 0,0, attr=0x07 the next cycle.

Source files
------------

// File: rtl/charbuf_writer.sv
// ----------------------------------------------------------------------------
// charbuf_writer
//
// Producer for port A of the 64x32-cell colour character buffer. It takes a
// console byte stream over a valid/ready handshake, interprets a few control
// codes and writes 16-bit cells {attr[7:0], char[7:0]}. Attribute bytes have
// the background colour in the high nibble and the foreground in the low
// nibble. The block owns the cursor and the current attribute, and performs
// full-screen clears.
//
// Ports:
//   clk         system clock (shared with buffer port A)
//   rst         synchronous active-high reset
//   in_valid    input byte valid
//   in_ready    byte can be accepted this cycle
//   in_data     input byte
//   wr_ce       buffer write enable (registered, one cycle per write)
//   wr_addr     buffer address {row[4:0], col[5:0]}
//   wr_data     cell {attr, char}
//   cursor_col  current column
//   cursor_row  current row
//   busy        high while a clear sequence is writing
//
// Control codes: 0x08 BS, 0x0A LF, 0x0C FF (clear), 0x0D CR,
// 0x1B ESC (next byte becomes the attribute). Everything else is a glyph.
//
// Build option: define CHARBUF_WRITER_CLEAR_ON_RESET_EN to run a full clear
// with DEFAULT_ATTR automatically after rst is released. Without it the block
// idles after reset and the buffer keeps its initial contents.
//
// States:
//   ST_IDLE     | decoding bytes, cursor writes
//   ST_ESC_ATTR | next accepted byte becomes the attribute
//   ST_CLEAR    | writing {attr,0x20} to every cell of rows 0..ROWS-1
// ----------------------------------------------------------------------------
module charbuf_writer #(
    parameter int          COLS         = 60,
    parameter int          ROWS         = 17,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        wr_ce,
    output logic [10:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ESC_ATTR = 2'd1,
        ST_CLEAR    = 2'd2
    } state_t;

    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    // The clear walks the full 64-cell stride, including invisible columns.
    localparam logic [10:0] CLR_LAST  = {LAST_ROW, 6'h3F};
    localparam logic [7:0]  CH_BS     = 8'h08;
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [7:0]  CH_FF     = 8'h0C;
    localparam logic [7:0]  CH_CR     = 8'h0D;
    localparam logic [7:0]  CH_ESC    = 8'h1B;
    localparam logic [7:0]  CH_SPACE  = 8'h20;

    state_t        state_q, state_d;
    logic [5:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [7:0]    attr_q, attr_d;
    logic [10:0]   clr_addr_q, clr_addr_d;
    logic          wr_ce_q, wr_ce_d;
    logic [10:0]   wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          start_clr;
    logic          accept;
    logic [4:0]    row_inc;

`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
    logic          start_clr_q, start_clr_d;
    assign start_clr = start_clr_q;
`else
    assign start_clr = 1'b0;
`endif

    // busy_q tracks the cycles in which a clear write is on the outputs, so
    // in_ready stays low through the last clear write even though the state
    // has already returned to IDLE.
    assign in_ready   = !rst && !busy_q && !start_clr;
    assign accept     = in_valid && in_ready;
    assign row_inc    = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

    assign wr_ce      = wr_ce_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        attr_d     = attr_q;
        clr_addr_d = clr_addr_q;
        wr_ce_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = 1'b0;
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
        start_clr_d = start_clr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_clr) begin
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
                    start_clr_d = 1'b0;
`endif
                    state_d    = ST_CLEAR;
                    wr_ce_d    = 1'b1;
                    wr_addr_d  = 11'd0;
                    wr_data_d  = {attr_q, CH_SPACE};
                    clr_addr_d = 11'd1;
                    busy_d     = 1'b1;
                end else if (accept) begin
                    case (in_data)
                        CH_BS: begin
                            if (col_q != 6'd0) begin
                                col_d     = col_q - 6'd1;
                                wr_ce_d   = 1'b1;
                                wr_addr_d = {row_q, col_q - 6'd1};
                                wr_data_d = {attr_q, CH_SPACE};
                            end
                        end
                        CH_LF:  row_d = row_inc;
                        CH_CR:  col_d = 6'd0;
                        CH_ESC: state_d = ST_ESC_ATTR;
                        CH_FF: begin
                            // First clear write is issued on the accepting edge.
                            state_d    = ST_CLEAR;
                            wr_ce_d    = 1'b1;
                            wr_addr_d  = 11'd0;
                            wr_data_d  = {attr_q, CH_SPACE};
                            clr_addr_d = 11'd1;
                            busy_d     = 1'b1;
                        end
                        default: begin
                            wr_ce_d   = 1'b1;
                            wr_addr_d = {row_q, col_q};
                            wr_data_d = {attr_q, in_data};
                            if (col_q == LAST_COL) begin
                                col_d = 6'd0;
                                row_d = row_inc;
                            end else begin
                                col_d = col_q + 6'd1;
                            end
                        end
                    endcase
                end
            end

            ST_ESC_ATTR: begin
                if (accept) begin
                    attr_d  = in_data;
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                wr_ce_d   = 1'b1;
                wr_addr_d = clr_addr_q;
                wr_data_d = {attr_q, CH_SPACE};
                busy_d    = 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = ST_IDLE;
                    col_d      = 6'd0;
                    row_d      = 5'd0;
                    clr_addr_d = 11'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 11'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= 6'd0;
            row_q      <= 5'd0;
            attr_q     <= DEFAULT_ATTR;
            clr_addr_q <= 11'd0;
            wr_ce_q    <= 1'b0;
            wr_addr_q  <= 11'd0;
            wr_data_q  <= 16'd0;
            busy_q     <= 1'b0;
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
            start_clr_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            attr_q     <= attr_d;
            clr_addr_q <= clr_addr_d;
            wr_ce_q    <= wr_ce_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
            start_clr_q <= start_clr_d;
`endif
        end
    end

endmodule

// File: tb/tb_charbuf_writer.sv
// ----------------------------------------------------------------------------
// tb_charbuf_writer
//
// Directed bench for charbuf_writer (default build, COLS=60, ROWS=17,
// DEFAULT_ATTR=8'h07). Inputs change 1 ns after a rising edge; outputs are
// inspected at that same point, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_charbuf_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        wr_ce;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    charbuf_writer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr_ce      (wr_ce),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a byte for one edge; returns 1 ns after that edge, when the
    // resulting write (if any) is on the outputs.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({wr_ce, wr_addr, wr_data, busy} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ce=%b addr=%h data=%h busy=%b, want all 0",
                     wr_ce, wr_addr, wr_data, busy);
        end
        n_tests++;
        if ({cursor_row, cursor_col} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_cursor: got row=%0d col=%0d, want 0,0", cursor_row, cursor_col);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_in_rst: got %b, want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_char();
        send_byte(8'h41);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h000 || wr_data !== 16'h0741) begin
            n_fail++;
            $display("FAIL char_write: got ce=%b addr=%h data=%h, want 1 000 0741",
                     wr_ce, wr_addr, wr_data);
        end
        n_tests++;
        if (cursor_col !== 6'd1 || cursor_row !== 5'd0) begin
            n_fail++;
            $display("FAIL char_cursor: got row=%0d col=%0d, want 0,1", cursor_row, cursor_col);
        end
        step();
        n_tests++;
        if (wr_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL char_single_cycle: got ce=%b, want 0", wr_ce);
        end
        // Glyph range above 0x7F is written like any other character.
        send_byte(8'h80);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h001 || wr_data !== 16'h0780) begin
            n_fail++;
            $display("FAIL char_high_glyph: got ce=%b addr=%h data=%h, want 1 001 0780",
                     wr_ce, wr_addr, wr_data);
        end
    endtask

    task automatic test_esc_attr();
        int bad = 0;
        send_byte(8'h1B);
        if (wr_ce !== 1'b0) bad++;
        send_byte(8'h1E);
        if (wr_ce !== 1'b0) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL esc_no_write: %0d of 2 esc bytes produced a write, want 0", bad);
        end
        send_byte(8'h78);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h002 || wr_data !== 16'h1E78) begin
            n_fail++;
            $display("FAIL esc_attr_write: got ce=%b addr=%h data=%h, want 1 002 1E78",
                     wr_ce, wr_addr, wr_data);
        end
        send_byte(8'h1B);
        send_byte(8'h07);
        send_byte(8'h79);
        n_tests++;
        if (wr_data !== 16'h0779 || wr_addr !== 11'h003) begin
            n_fail++;
            $display("FAIL esc_attr_restore: got addr=%h data=%h, want 003 0779", wr_addr, wr_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h0A);
        for (int i = 0; i < 59; i++) send_byte(8'h71);
        n_tests++;
        if (cursor_col !== 6'd59 || cursor_row !== 5'd16) begin
            n_fail++;
            $display("FAIL wrap_position: got row=%0d col=%0d, want 16,59", cursor_row, cursor_col);
        end
        send_byte(8'h5A);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h43B || wr_data !== 16'h075A) begin
            n_fail++;
            $display("FAIL wrap_write: got ce=%b addr=%h data=%h, want 1 43B 075A",
                     wr_ce, wr_addr, wr_data);
        end
        n_tests++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_cursor: got row=%0d col=%0d, want 0,0", cursor_row, cursor_col);
        end
        for (int i = 0; i < 17; i++) send_byte(8'h0A);
        n_tests++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0 || wr_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL lf_wrap: got row=%0d col=%0d ce=%b, want 0,0 ce 0",
                     cursor_row, cursor_col, wr_ce);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h08);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h001 || wr_data !== 16'h0720 || cursor_col !== 6'd1) begin
            n_fail++;
            $display("FAIL bs_write: got ce=%b addr=%h data=%h col=%0d, want 1 001 0720 col 1",
                     wr_ce, wr_addr, wr_data, cursor_col);
        end
        send_byte(8'h0D);
        n_tests++;
        if (wr_ce !== 1'b0 || cursor_col !== 6'd0) begin
            n_fail++;
            $display("FAIL cr: got ce=%b col=%0d, want ce 0 col 0", wr_ce, cursor_col);
        end
        send_byte(8'h08);
        n_tests++;
        if (wr_ce !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            n_fail++;
            $display("FAIL bs_at_col0: got ce=%b row=%0d col=%0d, want ce 0 at 0,0",
                     wr_ce, cursor_row, cursor_col);
        end
    endtask

    task automatic test_clear();
        int bad = 0;
        int first_bad = -1;
        do_reset();
        send_byte(8'h0A);
        send_byte(8'h41);
        send_byte(8'h0C);
        // A pending byte during the clear must not be accepted.
        in_valid = 1'b1;
        in_data  = 8'h51;
        for (int i = 0; i < 1088; i++) begin
            if (wr_ce !== 1'b1 || wr_addr !== 11'(i) || wr_data !== 16'h0720 ||
                busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (i == 1087) in_valid = 1'b0;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_sequence: %0d bad cycles (first at %0d, addr=%h data=%h busy=%b), want 0",
                     bad, first_bad, wr_addr, wr_data, busy);
        end
        n_tests++;
        if (wr_ce !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_end: got ce=%b busy=%b ready=%b, want 0 0 1", wr_ce, busy, in_ready);
        end
        n_tests++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_cursor: got row=%0d col=%0d, want 0,0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad = 0;
        send_byte(8'h1B);
        send_byte(8'h2A);
        send_byte(8'h43);
        send_byte(8'h0C);
        for (int i = 0; i < 100; i++) begin
            if (wr_ce !== 1'b1 || wr_addr !== 11'(i) || wr_data !== 16'h2A20) bad++;
            if (i < 99) step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_attr: %0d of 100 writes wrong (last data=%h), want 0", bad, wr_data);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (wr_ce !== 1'b0 || busy !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got ce=%b busy=%b row=%0d col=%0d, want 0 0 0,0",
                     wr_ce, busy, cursor_row, cursor_col);
        end
        rst = 1'b0;
        #1;
        send_byte(8'h63);
        n_tests++;
        if (wr_ce !== 1'b1 || wr_addr !== 11'h000 || wr_data !== 16'h0763) begin
            n_fail++;
            $display("FAIL rst_attr_default: got ce=%b addr=%h data=%h, want 1 000 0763",
                     wr_ce, wr_addr, wr_data);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_char();
        test_esc_attr();
        test_wrap();
        test_backspace();
        test_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
